// File: rtl/cpu_test_harness.sv
// cpu_test_harness: divided CPU clock/reset generator with run sequencing and write-bus checkpoint monitor
module cpu_test_harness #(
  parameter int NUM_CHECKS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DIV_W = 24,
  parameter int CYC_W = 32,
  parameter bit STRICT = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_n,
  input  logic                         step_n,
  input  logic                         step_mode,
  input  logic [DIV_W-1:0]             half_period,
  input  logic [CYC_W-1:0]             max_cycles,
  input  logic [NUM_CHECKS*ADDR_W-1:0] chk_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0] chk_data,
  input  logic                         mem_we,
  input  logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_wdata,
  output logic                         cpu_clk,
  output logic                         cpu_reset,
  output logic                         running,
  output logic                         pass,
  output logic                         fail,
  output logic [1:0]                   fail_code,
  output logic [NUM_CHECKS-1:0]        hit_mask,
  output logic [CYC_W-1:0]             cycle_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE_PASS, DONE_FAIL} state_t;
  state_t state, state_next;
  logic [2:0] start_sync, step_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [CYC_W-1:0] cnt_next;
  logic [NUM_CHECKS-1:0] match, mism, next_hits;
  logic start_pulse, step_pulse, in_run, launch, abort;
  logic mode_r, credit, run_en, tick, rise, fall, timeout, all_hit, any_mism;

  assign start_pulse = start_sync[2] & ~start_sync[1];
  assign step_pulse = step_sync[2] & ~step_sync[1];
  assign in_run = state == RUN;
  assign launch = start_pulse & ~in_run;
  assign abort = start_pulse & in_run;
  assign run_en = in_run & (~mode_r | credit);
  assign tick = run_en & (div_cnt == half_period);
  assign rise = tick & ~cpu_clk;
  assign fall = tick & cpu_clk;
  assign cnt_next = &cycle_count ? cycle_count : cycle_count + CYC_W'(1);
  assign timeout = rise & (|max_cycles) & (cnt_next == max_cycles);
  assign next_hits = hit_mask | match;
  assign all_hit = &next_hits;
  assign any_mism = |mism;

  // Compare the write bus against every checkpoint; mismatches only count for unhit entries
  always_comb begin
    match = '0;
    mism = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      match[i] = mem_we && mem_addr == chk_addr[i*ADDR_W +: ADDR_W] && mem_wdata == chk_data[i*DATA_W +: DATA_W];
      mism[i] = STRICT && mem_we && mem_addr == chk_addr[i*ADDR_W +: ADDR_W] && mem_wdata != chk_data[i*DATA_W +: DATA_W] && !hit_mask[i];
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;

  // Abort beats everything; pass beats mismatch on the same falling tick
  always_comb begin
    state_next = state;
    if (in_run) state_next = abort ? IDLE : (fall && all_hit) ? DONE_PASS : ((fall && any_mism) || timeout) ? DONE_FAIL : RUN;
    else if (start_pulse) state_next = RUN;
  end

  // Status flags decoded from the state register
  always_comb begin
    running = state == RUN;
    pass = state == DONE_PASS;
    fail = state == DONE_FAIL;
  end

  // Button synchronisers, clock divider, step credit and run datapath
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      start_sync <= 3'b111;
      step_sync <= 3'b111;
      mode_r <= 1'b0;
      credit <= 1'b0;
      div_cnt <= '0;
      cpu_clk <= 1'b0;
      cpu_reset <= 1'b1;
      fail_code <= 2'b00;
      hit_mask <= '0;
      cycle_count <= '0;
    end else begin
      start_sync <= {start_sync[1:0], start_n};
      step_sync <= {step_sync[1:0], step_n};
      if (!in_run || (div_cnt == '0 && !cpu_clk)) mode_r <= step_mode;
      if (launch) begin
        hit_mask <= '0;
        cycle_count <= '0;
        div_cnt <= '0;
        cpu_clk <= 1'b0;
        cpu_reset <= 1'b0;
        credit <= 1'b0;
        fail_code <= 2'b00;
      end else if (abort) begin
        cpu_reset <= 1'b1;
        cpu_clk <= 1'b0;
        div_cnt <= '0;
        credit <= 1'b0;
      end else if (in_run) begin
        if (run_en) div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (rise) cycle_count <= cnt_next;
        if (fall) hit_mask <= next_hits;
        cpu_clk <= (state_next != RUN) ? 1'b0 : cpu_clk ^ tick;
        credit <= fall ? 1'b0 : (credit | step_pulse);
        if (state_next == DONE_FAIL) fail_code <= (fall && any_mism) ? 2'b10 : 2'b01;
      end
    end
endmodule

// File: tb/tb_cpu_test_harness.sv
// tb_cpu_test_harness: random and directed runs of a strict and a lenient harness against a cycle-level run model
module tb_cpu_test_harness;
  localparam int AW = 32, DW = 32, DV = 24, CW = 32;
  logic clk = 0, reset = 1, start_n = 1, step_n = 1, step_mode = 0;
  logic [DV-1:0] half_period = 0;
  logic [CW-1:0] max_cycles = 0;
  logic [AW-1:0] ca[2];
  logic [DW-1:0] cd[2];
  logic [2*AW-1:0] chk_addr;
  logic [2*DW-1:0] chk_data;
  logic mem_we = 0;
  logic [AW-1:0] mem_addr = 0;
  logic [DW-1:0] mem_wdata = 0;
  logic cpu_clk_o[2], cpu_reset_o[2], running_o[2], pass_o[2], fail_o[2];
  logic [1:0] fc_o[2], hm_o[2];
  logic [CW-1:0] cc_o[2];
  int checks = 0, errors = 0, rise_cnt = 0;
  logic we_p[64];
  logic [AW-1:0] ad_p[64];
  logic [DW-1:0] da_p[64];
  int plen;
  int m_oc[2], m_cyc[2];
  logic [1:0] m_hits[2];
  logic [1:0] eh[64];

  assign chk_addr = {ca[1], ca[0]};
  assign chk_data = {cd[1], cd[0]};

  cpu_test_harness #(.NUM_CHECKS(2), .ADDR_W(AW), .DATA_W(DW), .DIV_W(DV), .CYC_W(CW), .STRICT(1)) dut (
    .clk(clk), .reset(reset), .start_n(start_n), .step_n(step_n), .step_mode(step_mode),
    .half_period(half_period), .max_cycles(max_cycles), .chk_addr(chk_addr), .chk_data(chk_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_clk(cpu_clk_o[0]), .cpu_reset(cpu_reset_o[0]), .running(running_o[0]), .pass(pass_o[0]),
    .fail(fail_o[0]), .fail_code(fc_o[0]), .hit_mask(hm_o[0]), .cycle_count(cc_o[0]));

  cpu_test_harness #(.NUM_CHECKS(2), .ADDR_W(AW), .DATA_W(DW), .DIV_W(DV), .CYC_W(CW), .STRICT(0)) dut_lenient (
    .clk(clk), .reset(reset), .start_n(start_n), .step_n(step_n), .step_mode(step_mode),
    .half_period(half_period), .max_cycles(max_cycles), .chk_addr(chk_addr), .chk_data(chk_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_clk(cpu_clk_o[1]), .cpu_reset(cpu_reset_o[1]), .running(running_o[1]), .pass(pass_o[1]),
    .fail(fail_o[1]), .fail_code(fc_o[1]), .hit_mask(hm_o[1]), .cycle_count(cc_o[1]));

  always #5 clk = ~clk;
  always @(posedge cpu_clk_o[1]) rise_cnt++;

  task automatic clear_prog(input int len);
    plen = len;
    for (int k = 0; k < 64; k++) begin
      we_p[k] = 0;
      ad_p[k] = 0;
      da_p[k] = 0;
    end
  endtask

  // Walk the program one CPU cycle at a time: timeout is judged at the rise, writes at the fall
  task automatic model(input int s, input int max_c);
    logic [1:0] h, m, mm;
    h = 0;
    m_oc[s] = 3;
    m_cyc[s] = 0;
    for (int k = 1; k < 64; k++) begin
      if (s == 1) eh[k] = h;
      if (max_c != 0 && k == max_c) begin
        m_oc[s] = 1; m_cyc[s] = k; m_hits[s] = h;
        return;
      end
      if (k < plen && we_p[k]) begin
        m = 0; mm = 0;
        for (int i = 0; i < 2; i++)
          if (ad_p[k] == ca[i]) begin
            if (da_p[k] == cd[i]) m[i] = 1;
            else if (s == 0 && !h[i]) mm[i] = 1;
          end
        h = h | m;
        if (h == 2'b11) begin
          m_oc[s] = 0; m_cyc[s] = k; m_hits[s] = h;
          return;
        end
        if (mm != 0) begin
          m_oc[s] = 2; m_cyc[s] = k; m_hits[s] = h;
          return;
        end
      end
    end
    m_hits[s] = h;
  endtask

  task automatic press_start();
    start_n = 0;
    repeat (4) @(negedge clk);
    start_n = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic press_step();
    step_n = 0;
    repeat (3) @(negedge clk);
    step_n = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_prog(input int max_c);
    int k, n, t2, t3;
    logic pc;
    model(0, max_c);
    model(1, max_c);
    if (m_oc[0] == 3 || m_oc[1] == 3) begin
      errors++;
      $display("FAIL model_setup: program never terminates (max=%0d)", max_c);
      return;
    end
    max_cycles = max_c;
    k = 0; n = 0; t2 = 0; t3 = 0; pc = 0;
    start_n = 0;
    while (n < 6000 && (n < 6 || !((pass_o[0] | fail_o[0]) && (pass_o[1] | fail_o[1])))) begin
      @(negedge clk);
      n++;
      if (n == 4) start_n = 1;
      if (cpu_clk_o[1] && !pc) begin
        k++;
        if (k == 2) t2 = n;
        if (k == 3) t3 = n;
        if (k < 64) begin
          checks++;
          if (hm_o[1] !== eh[k] || cc_o[1] !== CW'(k)) begin
            errors++;
            $display("FAIL cycle_track k=%0d: hit_mask=%b cycle_count=%0d, expected %b %0d", k, hm_o[1], cc_o[1], eh[k], k);
          end
        end
        mem_we = (k < plen) ? we_p[k] : 1'b0;
        mem_addr = (k < plen) ? ad_p[k] : '0;
        mem_wdata = (k < plen) ? da_p[k] : '0;
      end else if (!cpu_clk_o[1] && pc) mem_we = 0;
      pc = cpu_clk_o[1];
    end
    start_n = 1;
    mem_we = 0;
    checks++;
    if (n >= 6000) begin
      errors++;
      $display("FAIL run_done: no completion within budget, got pass=%b/%b fail=%b/%b, expected both done", pass_o[0], pass_o[1], fail_o[0], fail_o[1]);
    end
    if (k >= 3) begin
      checks++;
      if (t3 - t2 != 2 * (int'(half_period) + 1)) begin
        errors++;
        $display("FAIL cpu_clk_period: got %0d clk, expected %0d", t3 - t2, 2 * (int'(half_period) + 1));
      end
    end
    repeat (20) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pass_o[d] !== (m_oc[d] == 0) || fail_o[d] !== (m_oc[d] != 0) || running_o[d] !== 1'b0 ||
          fc_o[d] !== ((m_oc[d] == 0) ? 2'b00 : 2'(m_oc[d])) || hm_o[d] !== m_hits[d] || cc_o[d] !== CW'(m_cyc[d]) ||
          cpu_clk_o[d] !== 1'b0 || cpu_reset_o[d] !== 1'b0) begin
        errors++;
        $display("FAIL run_result dut%0d: pass=%b fail=%b code=%b hits=%b cycles=%0d clk=%b rst=%b, expected outcome=%0d hits=%b cycles=%0d clk=0 rst=0",
                 d, pass_o[d], fail_o[d], fc_o[d], hm_o[d], cc_o[d], cpu_clk_o[d], cpu_reset_o[d], m_oc[d], m_hits[d], m_cyc[d]);
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cpu_clk_o[d] !== 1'b0 || cpu_reset_o[d] !== 1'b1 || running_o[d] !== 1'b0 || pass_o[d] !== 1'b0 ||
          fail_o[d] !== 1'b0 || fc_o[d] !== 2'b00 || hm_o[d] !== 2'b00 || cc_o[d] !== '0) begin
        errors++;
        $display("FAIL %s dut%0d: clk=%b rst=%b run=%b pass=%b fail=%b code=%b hits=%b cycles=%0d, expected 0 1 0 0 0 00 00 0",
                 name, d, cpu_clk_o[d], cpu_reset_o[d], running_o[d], pass_o[d], fail_o[d], fc_o[d], hm_o[d], cc_o[d]);
      end
    end
  endtask

  task automatic test_reset();
    ca[0] = 32'h14; ca[1] = 32'h1A; cd[0] = 7; cd[1] = 7;
    repeat (3) @(negedge clk);
    check_reset_values("reset_held");
    reset = 0;
    repeat (5) @(negedge clk);
    check_reset_values("reset_released");
  endtask

  task automatic test_pass();
    ca[0] = 32'h14; ca[1] = 32'h1A; cd[0] = 7; cd[1] = 7;
    half_period = 4;
    clear_prog(10);
    we_p[3] = 1; ad_p[3] = 32'h14; da_p[3] = 7;
    we_p[6] = 1; ad_p[6] = 32'h1A; da_p[6] = 7;
    run_prog(0);
  endtask

  task automatic test_timeout();
    half_period = 4;
    clear_prog(1);
    run_prog(50);
  endtask

  task automatic test_mismatch();
    half_period = 4;
    clear_prog(4);
    we_p[2] = 1; ad_p[2] = 32'h14; da_p[2] = 5;
    run_prog(20);
  endtask

  task automatic test_step();
    int r0;
    step_mode = 1; half_period = 6; max_cycles = 0;
    ca[0] = 32'h100; ca[1] = 32'h104;
    press_start();
    repeat (10) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (running_o[d] !== 1'b1 || cc_o[d] !== '0) begin
        errors++;
        $display("FAIL step_idle dut%0d: running=%b cycles=%0d, expected 1 0", d, running_o[d], cc_o[d]);
      end
    end
    r0 = rise_cnt;
    press_step();
    press_step();
    repeat (60) @(negedge clk);
    press_step();
    repeat (60) @(negedge clk);
    checks++;
    if (rise_cnt - r0 != 2) begin
      errors++;
      $display("FAIL step_rises: got %0d rising edges, expected 2", rise_cnt - r0);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cc_o[d] !== CW'(2) || cpu_clk_o[d] !== 1'b0 || running_o[d] !== 1'b1) begin
        errors++;
        $display("FAIL step_count dut%0d: cycles=%0d clk=%b running=%b, expected 2 0 1", d, cc_o[d], cpu_clk_o[d], running_o[d]);
      end
    end
    press_start();
    step_mode = 0;
    checks++;
    if (running_o[0] !== 1'b0 || cpu_reset_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL step_abort: running=%b cpu_reset=%b, expected 0 1", running_o[0], cpu_reset_o[0]);
    end
  endtask

  task automatic test_abort();
    int n;
    step_mode = 0; half_period = 2; max_cycles = 0;
    ca[0] = 32'h100; ca[1] = 32'h104;
    press_start();
    repeat (30) @(negedge clk);
    start_n = 0;
    n = 0;
    while (n < 10 && !(cpu_reset_o[0] && cpu_reset_o[1])) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n > 4 || running_o[0] !== 1'b0 || running_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_latency: %0d clk, running=%b/%b, expected <=4 clk and 0/0", n, running_o[0], running_o[1]);
    end
    start_n = 1;
    repeat (5) @(negedge clk);
    checks++;
    if (cpu_clk_o[0] !== 1'b0 || cpu_clk_o[1] !== 1'b0 || cc_o[0] == '0) begin
      errors++;
      $display("FAIL abort_hold: cpu_clk=%b/%b cycles=%0d, expected 0/0 and nonzero count", cpu_clk_o[0], cpu_clk_o[1], cc_o[0]);
    end
    start_n = 0;
    n = 0;
    while (n < 10 && !running_o[0]) begin
      @(negedge clk);
      n++;
    end
    start_n = 1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (running_o[d] !== 1'b1 || cc_o[d] !== '0 || hm_o[d] !== 2'b00 || cpu_reset_o[d] !== 1'b0) begin
        errors++;
        $display("FAIL restart dut%0d: running=%b cycles=%0d hits=%b rst=%b, expected 1 0 00 0", d, running_o[d], cc_o[d], hm_o[d], cpu_reset_o[d]);
      end
    end
    repeat (4) @(negedge clk);
    press_start();
  endtask

  task automatic test_async_reset();
    int n;
    ca[0] = 32'h20; ca[1] = 32'h30; cd[0] = 9; cd[1] = 9;
    half_period = 1; max_cycles = 0;
    mem_we = 1; mem_addr = 32'h20; mem_wdata = 9;
    press_start();
    n = 0;
    while (n < 200 && hm_o[1] !== 2'b01) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (hm_o[0] !== 2'b01 || hm_o[1] !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset_hits: got %b/%b, expected 01/01", hm_o[0], hm_o[1]);
    end
    #2 reset = 1;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    reset = 0;
    mem_we = 0;
    repeat (3) @(negedge clk);
    ca[0] = 32'h40; ca[1] = 32'h40; cd[0] = 3; cd[1] = 3;
    clear_prog(4);
    we_p[2] = 1; ad_p[2] = 32'h40; da_p[2] = 3;
    run_prog(10);
  endtask

  task automatic test_random();
    int mx, sel;
    for (int it = 0; it < 10; it++) begin
      half_period = DV'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        ca[i] = 32'h10 + 4 * $urandom_range(0, 2);
        cd[i] = $urandom_range(1, 3);
      end
      mx = $urandom_range(6, 30);
      clear_prog(mx + 1);
      for (int k = 1; k < plen; k++) begin
        we_p[k] = $urandom_range(0, 1) == 1;
        sel = $urandom_range(0, 2);
        ad_p[k] = (sel < 2) ? ca[sel] : 32'h10 + 4 * $urandom_range(0, 3);
        da_p[k] = $urandom_range(1, 3);
      end
      run_prog(mx);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_timeout();
    test_mismatch();
    test_step();
    test_abort();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_test_harness.md
Name: cpu_test_harness

Overview:
- Board-level harness that runs a soft CPU core from a fast board clock.
- Generates a divided CPU clock and a CPU reset, and sequences runs from a start button.
- Supports free-run and single-step modes.
- Watches the CPU data-memory write bus against NUM_CHECKS programmable address/data checkpoints and reports pass, timeout or mismatch failure, plus cycle count and per-checkpoint hit flags for LEDs.

Parameters:
- NUM_CHECKS, 2, number of address/data checkpoints (1..16).
- ADDR_W, 32, CPU data address width.
- DATA_W, 32, CPU write data width.
- DIV_W, 24, width of the half-period divider input and counter.
- CYC_W, 32, width of the CPU cycle counter.
- STRICT, 0, 1 = a write to an unhit checkpoint address with wrong data fails the run.

Ports:
- clk  in  1  board clock.
- reset  in  1  reset, asynchronous, active-high.
- start_n  in  1  start/abort button, active-low, asynchronous, debounced externally.
- step_n  in  1  single-step button, active-low, asynchronous, debounced externally.
- step_mode  in  1  1 = single-step, 0 = free-run; level, sampled each clk.
- half_period  in  DIV_W  CPU clock half-period in clk cycles, minus 1.
- max_cycles  in  CYC_W  timeout threshold in CPU rising edges; 0 disables timeout.
- chk_addr  in  NUM_CHECKS*ADDR_W  checkpoint addresses, entry i at bits [i*ADDR_W +: ADDR_W].
- chk_data  in  NUM_CHECKS*DATA_W  expected write data, same packing.
- mem_we  in  1  CPU data write enable.
- mem_addr  in  ADDR_W  CPU data address.
- mem_wdata  in  DATA_W  CPU write data.
- cpu_clk  out  1  divided CPU clock, a register.
- cpu_reset  out  1  CPU reset, active-high.
- running  out  1  high in RUN.
- pass  out  1  high in DONE_PASS.
- fail  out  1  high in DONE_FAIL.
- fail_code  out  2  00 none, 01 timeout, 10 mismatch.
- hit_mask  out  NUM_CHECKS  bit i set once checkpoint i has been matched.
- cycle_count  out  CYC_W  CPU rising edges since run start; saturating.

Behaviour:
- Reset values:
  - state=IDLE, cpu_clk=0, cpu_reset=1.
  - running=0, pass=0, fail=0, fail_code=00.
  - hit_mask=0, cycle_count=0, divider=0, step credit=0.
  - Both synchroniser chains preset to 1.
- Buttons:
  - Each button passes through a 2-FF synchroniser.
  - A press is a synced 1->0 transition and yields a one-clk pulse.
  - Press-to-pulse latency is 3 clk.
- Divider:
  - Active only in RUN with clock enabled.
  - When the counter equals half_period: counter returns to 0, tick=1, cpu_clk toggles.
  - Otherwise the counter increments.
  - half_period=0 gives cpu_clk = clk/2.
  - half_period is sampled continuously; a change takes effect at the next compare.
- Clock enable:
  - Free-run: the clock is always enabled.
  - Step mode: the clock is enabled only while step credit=1.
  - A step press sets credit=1 only when credit=0; a press while credit=1 is ignored.
  - Credit clears on the falling-edge tick, so each press yields exactly one full CPU period.
  - Switching step_mode mid-run takes effect at the next tick boundary; cpu_clk never shortens a phase.
- Rising tick (cpu_clk 0->1): cycle_count += 1, saturating at all-ones.
- Falling tick (cpu_clk 1->0):
  - Sample mem_we, mem_addr and mem_wdata on this same clk edge.
  - match[i] = mem_we & addr==chk_addr[i] & wdata==chk_data[i].
  - mism[i] = STRICT & mem_we & addr==chk_addr[i] & wdata!=chk_data[i] & !hit_mask[i].
  - next_hits = hit_mask | match.
- State machine, evaluated on each clk:
  - IDLE: on start pulse -> RUN. Clear hit_mask, cycle_count and divider; cpu_clk=0, cpu_reset=0, step credit=0.
  - RUN, start pulse: abort -> IDLE, cpu_reset=1, cpu_clk=0. Abort has priority over every other event.
  - RUN, falling tick with next_hits all-ones: -> DONE_PASS.
  - Else RUN, falling tick with any mism: -> DONE_FAIL, fail_code=10. Pass wins if both occur.
  - Else RUN, max_cycles!=0 and cycle_count reaches max_cycles: -> DONE_FAIL, fail_code=01. Evaluated on the rising tick that makes cycle_count == max_cycles.
  - DONE_PASS / DONE_FAIL: cpu_clk held at 0, cpu_reset=0 so CPU state stays inspectable, hit_mask and cycle_count frozen. A start pulse begins a new run exactly as from IDLE.
- Outputs are registered and reflect the state one clk after the deciding edge.
- Asynchronous reset mid-run forces reset values immediately, including cpu_reset=1.
- Checkpoints with identical address and data are all set by the same write.
- A write that matches an already-hit checkpoint again has no effect.

Test Plan:
1. NUM_CHECKS=2, chk=(0x14,7),(0x1A,7), half_period=4, step_mode=0, press start; bus writes 7@0x14, then 7@0x1A -> hit_mask 01 then 11, pass=1, fail=0, cpu_clk stops low, cycle_count frozen.
2. Same setup, max_cycles=50, no matching writes -> fail=1, fail_code=01 when cycle_count=50; cpu_clk period=10 clk.
3. STRICT=1, write 5@0x14 -> fail_code=10; repeat with STRICT=0 -> run continues, hit_mask=00.
4. step_mode=1, press start then step three times, including a step press during an active step -> exactly 2 rising edges, cycle_count=2.
5. Press start mid-run -> cpu_reset=1 and state IDLE within 4 clk; press again -> counters cleared, new run.
6. Assert reset during RUN with hit_mask=01 -> all outputs at reset values asynchronously; a single write matching both checkpoints sets both bits on one falling tick.
